sram_2p_march_bist: RTL and testbench

- Upstream March C- BIST engine for the IHP 2-port SRAM core (DATA_WIDTH x 2^ADDR_WIDTH).
- Drives the macro's A_BIST_* inputs (and B_BIST_* when the optional feature is compiled in) and checks the registered read data coming back.
- Reports pass/fail, the first failing address and element, and a saturating error count to the SoC test controller.

---
 rtl/sram_2p_march_bist.sv | 245 ++++++++++++++++++++++++
 tb/tb_sram_2p_march_bist.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_2p_march_bist.sv
// -----------------------------------------------------------------------------
// sram_2p_march_bist
//   March C- BIST engine for the IHP 2-port SRAM core (DATA_WIDTH x 2^ADDR_WIDTH).
//   It drives the macro's BIST port(s) with one op per cycle (10N ops) and
//   checks the registered read data two cycles after each read is issued.
//
//   Ports:
//     CLK, RST_N (synchronous, active-low), START (level)
//     BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, ERR_CNT : status to the test controller
//     A_BIST_{EN,MEN,WEN,REN,ADDR,DIN,BM}, A_DOUT    : SRAM port A
//     B_BIST_{EN,MEN,WEN,REN,ADDR,DIN,BM}, B_DOUT    : SRAM port B
//
//   Optional feature macro: SRAM_BIST_PORTB_EN
//     defined   : writes on port A, reads on port B (cross-port test), B_DOUT checked
//     undefined : all ops on port A, B_BIST_* tied to 0, B_DOUT ignored
// -----------------------------------------------------------------------------
module sram_2p_march_bist #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDR_WIDTH    = 9,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     FAIL,
  output logic [ADDR_WIDTH-1:0]    FAIL_ADDR,
  output logic [2:0]               FAIL_ELEM,
  output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
  output logic                     A_BIST_EN,
  output logic                     A_BIST_MEN,
  output logic                     A_BIST_WEN,
  output logic                     A_BIST_REN,
  output logic [ADDR_WIDTH-1:0]    A_BIST_ADDR,
  output logic [DATA_WIDTH-1:0]    A_BIST_DIN,
  output logic [DATA_WIDTH-1:0]    A_BIST_BM,
  input  logic [DATA_WIDTH-1:0]    A_DOUT,
  output logic                     B_BIST_EN,
  output logic                     B_BIST_MEN,
  output logic                     B_BIST_WEN,
  output logic                     B_BIST_REN,
  output logic [ADDR_WIDTH-1:0]    B_BIST_ADDR,
  output logic [DATA_WIDTH-1:0]    B_BIST_DIN,
  output logic [DATA_WIDTH-1:0]    B_BIST_BM,
  input  logic [DATA_WIDTH-1:0]    B_DOUT
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic                    drain_q, drain_d;
  logic                    load, go;
  logic                    desc;
  logic [ADDR_WIDTH-1:0]   last_addr;

  logic                    nxt_wr, nxt_rd, run_d;
  logic                    wbg, rbg;

  logic                    vld_p0, vld_p1;
  logic                    exp_p0, exp_p1;
  logic [ADDR_WIDTH-1:0]   addr_p0, addr_p1;
  logic [2:0]              elem_p0, elem_p1;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    mismatch;
  logic                    unused_dout;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      elem_q  <= 3'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      drain_q <= drain_d;
    end
  end

  // elem/addr/wr describe the op currently on the outputs; the *_d values
  // are the op that will be presented after the next edge.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    drain_d   = drain_q;
    load      = 1'b0;
    go        = 1'b0;
    desc      = (elem_q == 3'd3) || (elem_q == 3'd4);
    last_addr = desc ? '0 : '1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          go      = 1'b1;
          state_d = S_RUN;
          elem_d  = 3'd0;
          addr_d  = '0;
          wr_d    = 1'b1;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (!wr_q && (elem_q != 3'd5)) begin
          // read-then-write pair: write the same address next cycle
          wr_d = 1'b1;
          load = 1'b1;
        end else if (addr_q != last_addr) begin
          addr_d = desc ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
          wr_d   = (elem_q == 3'd0);
          load   = 1'b1;
        end else if (elem_q == 3'd5) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          elem_d = elem_q + 3'd1;
          addr_d = ((elem_d == 3'd3) || (elem_d == 3'd4)) ? '1 : '0;
          wr_d   = 1'b0;
          load   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Backgrounds: M0,M2,M4 write D0 and M1,M3 write D1; M1,M3,M5 read D0 and M2,M4 read D1.
  assign nxt_wr = load & wr_d;
  assign nxt_rd = load & ~wr_d;
  assign wbg    = elem_d[0];
  assign rbg    = ~elem_d[0];
  assign run_d  = (state_d == S_RUN) || (state_d == S_DRAIN);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      A_BIST_EN   <= 1'b0;
      A_BIST_MEN  <= 1'b0;
      A_BIST_WEN  <= 1'b0;
      A_BIST_REN  <= 1'b0;
      A_BIST_ADDR <= '0;
      A_BIST_DIN  <= '0;
      A_BIST_BM   <= '0;
`ifdef SRAM_BIST_PORTB_EN
      B_BIST_EN   <= 1'b0;
      B_BIST_MEN  <= 1'b0;
      B_BIST_REN  <= 1'b0;
      B_BIST_ADDR <= '0;
`endif
    end else begin
      BUSY        <= run_d;
      DONE        <= (state_d == S_DONE);
      A_BIST_EN   <= run_d;
      A_BIST_WEN  <= nxt_wr;
      A_BIST_ADDR <= addr_d;
      A_BIST_DIN  <= (nxt_wr && wbg) ? '1 : '0;
      A_BIST_BM   <= nxt_wr ? '1 : '0;
`ifdef SRAM_BIST_PORTB_EN
      A_BIST_MEN  <= nxt_wr;
      A_BIST_REN  <= 1'b0;
      B_BIST_EN   <= run_d;
      B_BIST_MEN  <= nxt_rd;
      B_BIST_REN  <= nxt_rd;
      B_BIST_ADDR <= addr_d;
`else
      A_BIST_MEN  <= load;
      A_BIST_REN  <= nxt_rd;
`endif
    end
  end

`ifdef SRAM_BIST_PORTB_EN
  assign B_BIST_WEN  = 1'b0;
  assign B_BIST_DIN  = '0;
  assign B_BIST_BM   = '0;
  assign rd_data     = B_DOUT;
  assign unused_dout = ^A_DOUT;
`else
  assign B_BIST_EN   = 1'b0;
  assign B_BIST_MEN  = 1'b0;
  assign B_BIST_WEN  = 1'b0;
  assign B_BIST_REN  = 1'b0;
  assign B_BIST_ADDR = '0;
  assign B_BIST_DIN  = '0;
  assign B_BIST_BM   = '0;
  assign rd_data     = A_DOUT;
  assign unused_dout = ^B_DOUT;
`endif

  // p0: read issued on the BIST port
  // p1: SRAM has sampled the read; DOUT holds the word during this stage
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= nxt_rd;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge CLK) begin
    exp_p0  <= rbg;
    addr_p0 <= addr_d;
    elem_p0 <= elem_d;
    exp_p1  <= exp_p0;
    addr_p1 <= addr_p0;
    elem_p1 <= elem_p0;
  end

  // p2: compare and update the result registers
  assign mismatch = vld_p1 && (rd_data != {DATA_WIDTH{exp_p1}});

  always_ff @(posedge CLK) begin
    if (!RST_N || go) begin
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= 3'd0;
      ERR_CNT   <= '0;
    end else if (mismatch) begin
      ERR_CNT <= sat_inc(ERR_CNT);
      if (!FAIL) begin
        FAIL      <= 1'b1;
        FAIL_ADDR <= addr_p1;
        FAIL_ELEM <= elem_p1;
      end
    end
  end

endmodule

// File: tb/tb_sram_2p_march_bist.sv
`timescale 1ns/1ps
module tb_sram_2p_march_bist;

  localparam int DW   = 20;
  localparam int AW   = 9;
  localparam int EW   = 8;
  localparam int N    = 1 << AW;
  localparam int NOPS = 10 * N;
`ifdef SRAM_BIST_PORTB_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0;
  logic          BUSY, DONE, FAIL;
  logic [AW-1:0] FAIL_ADDR;
  logic [2:0]    FAIL_ELEM;
  logic [EW-1:0] ERR_CNT;
  logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
  logic [AW-1:0] A_BIST_ADDR;
  logic [DW-1:0] A_BIST_DIN, A_BIST_BM;
  logic [DW-1:0] A_DOUT = '0;
  logic          B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN;
  logic [AW-1:0] B_BIST_ADDR;
  logic [DW-1:0] B_BIST_DIN, B_BIST_BM;
  logic [DW-1:0] B_DOUT = '0;

  always #5 CLK = ~CLK;

  sram_2p_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(EW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .FAIL_ADDR(FAIL_ADDR),
    .FAIL_ELEM(FAIL_ELEM), .ERR_CNT(ERR_CNT),
    .A_BIST_EN(A_BIST_EN), .A_BIST_MEN(A_BIST_MEN), .A_BIST_WEN(A_BIST_WEN),
    .A_BIST_REN(A_BIST_REN), .A_BIST_ADDR(A_BIST_ADDR), .A_BIST_DIN(A_BIST_DIN),
    .A_BIST_BM(A_BIST_BM), .A_DOUT(A_DOUT),
    .B_BIST_EN(B_BIST_EN), .B_BIST_MEN(B_BIST_MEN), .B_BIST_WEN(B_BIST_WEN),
    .B_BIST_REN(B_BIST_REN), .B_BIST_ADDR(B_BIST_ADDR), .B_BIST_DIN(B_BIST_DIN),
    .B_BIST_BM(B_BIST_BM), .B_DOUT(B_DOUT)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Fault injected on the read data returned by one SRAM port.
  bit f_en = 1'b0, f_all = 1'b0, f_port = 1'b0, f_val = 1'b0;
  int f_addr = 0, f_bit = 0;

  function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] w, input int a, input bit port);
    if (f_en && (f_port == port) && (f_all || (a == f_addr))) w[f_bit] = f_val;
    return w;
  endfunction

  // Behavioural 2-port SRAM with registered read data.
  logic [DW-1:0] mem [N];
  always @(posedge CLK) begin
    if (A_BIST_EN && A_BIST_MEN && A_BIST_WEN)
      mem[A_BIST_ADDR] <= (mem[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
    if (A_BIST_EN && A_BIST_MEN && A_BIST_REN)
      A_DOUT <= apply_fault(mem[A_BIST_ADDR], int'(A_BIST_ADDR), 1'b0);
    if (B_BIST_EN && B_BIST_MEN && B_BIST_WEN)
      mem[B_BIST_ADDR] <= (mem[B_BIST_ADDR] & ~B_BIST_BM) | (B_BIST_DIN & B_BIST_BM);
    if (B_BIST_EN && B_BIST_MEN && B_BIST_REN)
      B_DOUT <= apply_fault(mem[B_BIST_ADDR], int'(B_BIST_ADDR), 1'b1);
  end

  // Reference March C- op list.
  typedef struct { bit wr; int addr; bit bg; int elem; } op_t;
  op_t ops[$];

  task automatic build_ops();
    bit rd_bg [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit wr_bg [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    op_t o;
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        o.addr = (e == 3 || e == 4) ? (N - 1 - i) : i;
        o.elem = e;
        if (e > 0) begin o.wr = 1'b0; o.bg = rd_bg[e]; ops.push_back(o); end
        if (e < 5) begin o.wr = 1'b1; o.bg = wr_bg[e]; ops.push_back(o); end
      end
    end
  endtask

  // Expected result: memory holds the last written background, so every read
  // returns its background unless the fault on the read port alters it.
  task automatic predict(output bit fail, output int faddr, output int felem, output int ecnt);
    logic [DW-1:0] good, seen;
    fail = 1'b0; faddr = 0; felem = 0; ecnt = 0;
    foreach (ops[i]) begin
      if (!ops[i].wr) begin
        good = {DW{ops[i].bg}};
        seen = apply_fault(good, ops[i].addr, PB);
        if (seen != good) begin
          if (ecnt < (1 << EW) - 1) ecnt++;
          if (!fail) begin fail = 1'b1; faddr = ops[i].addr; felem = ops[i].elem; end
        end
      end
    end
  endtask

  // Port view: address/data ignored when the port is idle, mask only on writes.
  function automatic logic [63:0] pv(input logic en, input logic men, input logic wen, input logic ren,
                                     input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    if (!men) begin a = '0; d = '0; m = '0; end
    if (!wen) m = '0;
    return {11'b0, en, men, wen, ren, a, d, m};
  endfunction

  function automatic logic [63:0] raw_a();
    return {11'b0, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM};
  endfunction
  function automatic logic [63:0] raw_b();
    return {11'b0, B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN, B_BIST_ADDR, B_BIST_DIN, B_BIST_BM};
  endfunction
  function automatic logic [63:0] got_a();
    return pv(A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM);
  endfunction
  function automatic logic [63:0] got_b();
    return PB ? pv(B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN, B_BIST_ADDR, B_BIST_DIN, B_BIST_BM) : raw_b();
  endfunction

  function automatic logic [63:0] exp_a(input op_t o);
    if (o.wr) return pv(1'b1, 1'b1, 1'b1, 1'b0, AW'(o.addr), {DW{o.bg}}, '1);
    if (PB)   return pv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    return pv(1'b1, 1'b1, 1'b0, 1'b1, AW'(o.addr), '0, '0);
  endfunction
  function automatic logic [63:0] exp_b(input op_t o);
    if (!PB) return 64'd0;
    if (o.wr) return pv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    return pv(1'b1, 1'b1, 1'b0, 1'b1, AW'(o.addr), '0, '0);
  endfunction

  // One test run starting from IDLE/DONE. abort_at: edge at which RST_N is
  // low for one cycle; pulse_at: edge at which a stray START is seen;
  // hold: START kept high throughout.
  task automatic run_test(input int abort_at, input int pulse_at, input bit hold);
    bit efail;
    int eaddr, eelem, ecnt;
    predict(efail, eaddr, eelem, ecnt);
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK); #1;
    for (int k = 0; k < NOPS + 2; k++) begin
      if (k == 0) chk("clr", 64'({FAIL, FAIL_ADDR, FAIL_ELEM, ERR_CNT}), 64'd0);
      chk("busy", 64'({BUSY, DONE}), 64'd2);
      if (k < NOPS) begin
        chk("opa", got_a(), exp_a(ops[k]));
        chk("opb", got_b(), exp_b(ops[k]));
      end else begin
        chk("drain_a", got_a(), pv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0));
        chk("drain_b", got_b(), PB ? pv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0) : 64'd0);
      end
      START = hold || (k + 1 == pulse_at);
      RST_N = !(k + 1 == abort_at);
      @(posedge CLK); #1;
      if (k + 1 == abort_at) begin
        RST_N = 1'b1;
        START = 1'b0;
        chk("abort_ctl", 64'({BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, ERR_CNT}), 64'd0);
        chk("abort_a", raw_a(), 64'd0);
        chk("abort_b", raw_b(), 64'd0);
        return;
      end
    end
    chk("done", 64'({BUSY, DONE}), 64'd1);
    chk("fail", 64'(FAIL), 64'(efail));
    chk("fail_addr", 64'(FAIL_ADDR), 64'(eaddr));
    chk("fail_elem", 64'(FAIL_ELEM), 64'(eelem));
    chk("err_cnt", 64'(ERR_CNT), 64'(ecnt));
    chk("done_ctl", 64'({A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
                         B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN}), 64'd0);
    @(posedge CLK); #1;
    if (hold) begin
      chk("rerun", 64'({BUSY, DONE}), 64'd2);
      chk("rerun_op", got_a(), exp_a(ops[0]));
      START = 1'b0;
      RST_N = 1'b0;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      chk("rerun_rst", 64'({BUSY, DONE}), 64'd0);
    end else begin
      chk("done_hold", 64'({BUSY, DONE}), 64'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    build_ops();

    RST_N = 1'b0;
    START = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ctl", 64'({BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, ERR_CNT}), 64'd0);
    chk("rst_a", raw_a(), 64'd0);
    chk("rst_b", raw_b(), 64'd0);
    START = 1'b0;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("idle", 64'({BUSY, DONE, A_BIST_EN}), 64'd0);

    // fault-free pass
    run_test(0, 0, 1'b0);

    // bit 3 stuck-at-1 at 0x1A5 on the read port
    f_en = 1'b1; f_all = 1'b0; f_addr = 'h1A5; f_bit = 3; f_val = 1'b1; f_port = PB;
    run_test(0, 0, 1'b0);

    // every address faulty: counter saturates
    f_all = 1'b1;
    run_test(0, 0, 1'b0);

    // reset mid-run, then a clean pass
    f_en = 1'b0; f_all = 1'b0;
    run_test(1000, 0, 1'b0);
    run_test(0, 0, 1'b0);

    // stray START mid-run is ignored
    run_test(0, 300, 1'b0);

    // fault on port B read data only
    f_en = 1'b1; f_all = 1'b0; f_port = 1'b1;
    f_addr = $urandom_range(0, N - 1); f_bit = $urandom_range(0, DW - 1); f_val = 1'b1;
    run_test(0, 0, 1'b0);

    // randomized fault configurations
    for (int r = 0; r < 2; r++) begin
      f_en   = 1'b1;
      f_all  = ($urandom_range(0, 3) == 0);
      f_port = $urandom_range(0, 1);
      f_val  = $urandom_range(0, 1);
      f_bit  = $urandom_range(0, DW - 1);
      f_addr = $urandom_range(0, N - 1);
      run_test(0, 0, 1'b0);
    end

    // START held high: DONE for one cycle then a new run
    f_en = 1'b0;
    run_test(0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
